imem_boot_loader: RTL and testbench

Boot-time controller that owns the instruction memory write port. It receives a program image over an 8-bit valid/ready byte stream, packs the bytes into 32-bit little-endian words, and writes them into consecutive word addresses. It holds the single-cycle core in reset-hold until the image is fully committed, then releases it. It sits between the external load interface (UART/JTAG bridge) and the instruction memory; the core's fetch path is not routed through this block.

---
 rtl/imem_boot_pkg.sv | 23 ++
 rtl/imem_word_packer.sv | 47 ++++
 rtl/imem_boot_loader.sv | 155 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_pkg
// Description : Shared types and constants for the instruction-memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_boot_pkg;

  localparam int LEN_W          = 16;
  localparam int DEFAULT_DEPTH  = 64;
  localparam int DEFAULT_ADDR_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : imem_word_packer
// Description : Packs a byte stream into 32-bit little-endian words.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_data_o
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] shift_q, shift_d;

  // Bytes enter at the top and shift down, so byte 0 ends up in [7:0].
  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    if (clear_i) begin
      lane_d  = 2'd0;
      shift_d = 24'd0;
    end else if (byte_valid_i) begin
      lane_d  = lane_q + 2'd1;
      shift_d = {byte_i, shift_q[23:8]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q  <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
    end
  end

  assign word_valid_o = byte_valid_i && !clear_i && (lane_q == 2'd3);
  assign word_data_o  = {byte_i, shift_q};

endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_loader
// Description : Loads a length-prefixed program image into instruction memory
//               and holds the core until the image is committed.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              core_hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   words_loaded_o
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              core_hold_q, core_hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              w_accept;
  logic              w_start;
  logic [LEN_W-1:0]  w_len_full;
  logic [ADDR_W:0]   w_words_next;
  logic              w_last;
  logic              w_word_valid;
  logic [31:0]       w_word_data;

  assign in_ready_o   = (state_q == ST_LEN0) || (state_q == ST_LEN1) || (state_q == ST_DATA);
  assign w_accept     = in_valid_i && in_ready_o;
  assign w_start      = load_start_i &&
                        ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
  assign w_len_full   = {in_data_i, len_q[7:0]};
  assign w_words_next = (words_q == (ADDR_W+1)'(DEPTH)) ? words_q : words_q + 1'b1;
  assign w_last       = (LEN_W'(w_words_next) == len_q);

  imem_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (w_start),
    .byte_valid_i (w_accept && (state_q == ST_DATA)),
    .byte_i       (in_data_i),
    .word_valid_o (w_word_valid),
    .word_data_o  (w_word_data)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    words_d  = words_q;
    mem_we_d = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (w_start) begin
          state_d = ST_LEN0;
          len_d   = '0;
          words_d = '0;
        end
      end
      ST_LEN0: begin
        if (w_accept) begin
          len_d[7:0] = in_data_i;
          state_d    = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (w_accept) begin
          len_d = w_len_full;
          if (w_len_full == '0)
            state_d = ST_DONE;
          else if (w_len_full > LEN_W'(DEPTH))
            state_d = ST_ERR;
          else
            state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_word_valid) begin
          mem_we_d = 1'b1;
          waddr_d  = words_q[ADDR_W-1:0];
          wdata_d  = w_word_data;
          words_d  = w_words_next;
          if (w_last)
            state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d == ST_LEN0) || (state_d == ST_LEN1) || (state_d == ST_DATA);
    // Release one edge after DONE is entered so the final write is already in memory.
    done_d      = (state_q == ST_DONE) && (state_d == ST_DONE);
    err_d       = (state_d == ST_ERR);
    core_hold_d = !done_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      words_q     <= '0;
      mem_we_q    <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      core_hold_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      words_q     <= words_d;
      mem_we_q    <= mem_we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      core_hold_q <= core_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_we_o       = mem_we_q;
  assign mem_waddr_o    = waddr_q;
  assign mem_wdata_o    = wdata_q;
  assign core_hold_o    = core_hold_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign words_loaded_o = words_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_boot_loader
// Description : Directed self-checking bench for imem_boot_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start_i;
  logic        in_valid_i;
  logic [7:0]  in_data_i;
  logic        in_ready_o;
  logic        mem_we_o;
  logic [5:0]  mem_waddr_o;
  logic [31:0] mem_wdata_o;
  logic        core_hold_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [6:0]  words_loaded_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [37:0] wlog[$];
  logic [7:0]  img[16];
  int          img_n;

  imem_boot_loader #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .load_start_i   (load_start_i),
    .in_valid_i     (in_valid_i),
    .in_data_i      (in_data_i),
    .in_ready_o     (in_ready_o),
    .mem_we_o       (mem_we_o),
    .mem_waddr_o    (mem_waddr_o),
    .mem_wdata_o    (mem_wdata_o),
    .core_hold_o    (core_hold_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .words_loaded_o (words_loaded_o)
  );

  always #5 clk = ~clk;

  // Every memory write seen on the port, as {waddr, wdata}.
  always @(negedge clk) if (mem_we_o) wlog.push_back({mem_waddr_o, mem_wdata_o});

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [5:0] a, input logic [31:0] d);
    logic [37:0] v;
    v = (idx < wlog.size()) ? wlog[idx] : '1;
    check(tag, {26'd0, v}, {26'd0, a, d});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    acc        = 1'b0;
    in_valid_i = 1'b1;
    in_data_i  = b;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready_o;
      tick();
    end
    in_valid_i = 1'b0;
    if (!acc) check("byte_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_img(input bit throttle);
    for (int i = 0; i < img_n; i++) begin
      send_byte(img[i]);
      if (throttle && (i < img_n - 1)) begin
        in_data_i = 8'($urandom);
        tick();
        if (i >= 2) check("thr_ready", {63'd0, in_ready_o}, 64'd1);
      end
    end
  endtask

  task automatic set_img2(input logic [31:0] w0, input logic [31:0] w1);
    img = '{default: 8'h00};
    img[0] = 8'h02; img[1] = 8'h00;
    img[2] = w0[7:0];  img[3] = w0[15:8];  img[4] = w0[23:16]; img[5]  = w0[31:24];
    img[6] = w1[7:0];  img[7] = w1[15:8];  img[8] = w1[23:16]; img[9]  = w1[31:24];
    img_n  = 10;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    load_start_i = 1'b0;
    in_valid_i   = 1'b0;
    in_data_i    = 8'h00;
    tick();
    tick();
    check("rst_ready", {63'd0, in_ready_o}, 64'd0);
    check("rst_we",    {63'd0, mem_we_o},   64'd0);
    check("rst_waddr", {58'd0, mem_waddr_o}, 64'd0);
    check("rst_wdata", {32'd0, mem_wdata_o}, 64'd0);
    check("rst_hold",  {63'd0, core_hold_o}, 64'd1);
    check("rst_flags", {61'd0, busy_o, done_o, err_o}, 64'd0);
    check("rst_words", {57'd0, words_loaded_o}, 64'd0);
    rst = 1'b0;
    tick();

    // Normal full-rate load of two words.
    wlog.delete();
    pulse_start();
    check("n_busy", {63'd0, busy_o}, 64'd1);
    set_img2(32'h0000_0013, 32'h0010_0093);
    send_img(1'b0);
    check("n_we_last",   {63'd0, mem_we_o},    64'd1);
    check("n_done_early",{63'd0, done_o},      64'd0);
    check("n_hold_early",{63'd0, core_hold_o}, 64'd1);
    tick();
    check("n_done",  {63'd0, done_o},      64'd1);
    check("n_hold",  {63'd0, core_hold_o}, 64'd0);
    check("n_busy0", {63'd0, busy_o},      64'd0);
    check("n_words", {57'd0, words_loaded_o}, 64'd2);
    check("n_nwr",   64'(wlog.size()), 64'd2);
    check_wr("n_wr0", 0, 6'd0, 32'h0000_0013);
    check_wr("n_wr1", 1, 6'd1, 32'h0010_0093);

    // Same image with a throttled source, restarting from DONE.
    wlog.delete();
    pulse_start();
    check("t_hold", {63'd0, core_hold_o}, 64'd1);
    check("t_done", {63'd0, done_o},      64'd0);
    send_img(1'b1);
    tick();
    check("t_done2", {63'd0, done_o}, 64'd1);
    check("t_nwr",   64'(wlog.size()), 64'd2);
    check_wr("t_wr0", 0, 6'd0, 32'h0000_0013);
    check_wr("t_wr1", 1, 6'd1, 32'h0010_0093);

    // Zero-length header.
    wlog.delete();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    check("z_ready", {63'd0, in_ready_o}, 64'd0);
    check("z_busy",  {63'd0, busy_o},     64'd0);
    check("z_err",   {63'd0, err_o},      64'd0);
    check("z_words", {57'd0, words_loaded_o}, 64'd0);
    tick();
    check("z_done", {63'd0, done_o},      64'd1);
    check("z_hold", {63'd0, core_hold_o}, 64'd0);
    check("z_nwr",  64'(wlog.size()), 64'd0);

    // Oversize header, then recovery with a one-word image.
    wlog.delete();
    pulse_start();
    send_byte(8'h41);
    send_byte(8'h00);
    check("o_err",   {63'd0, err_o},       64'd1);
    check("o_hold",  {63'd0, core_hold_o}, 64'd1);
    check("o_ready", {63'd0, in_ready_o},  64'd0);
    check("o_busy",  {63'd0, busy_o},      64'd0);
    in_valid_i = 1'b1;
    in_data_i  = 8'hAA;
    tick(); tick(); tick();
    in_valid_i = 1'b0;
    check("o_nwr",  64'(wlog.size()), 64'd0);
    check("o_err2", {63'd0, err_o}, 64'd1);
    pulse_start();
    check("o_clr", {63'd0, err_o}, 64'd0);
    img[0] = 8'h01; img[1] = 8'h00;
    img[2] = 8'hEF; img[3] = 8'hBE; img[4] = 8'hAD; img[5] = 8'hDE;
    img_n  = 6;
    send_img(1'b0);
    tick();
    check("o_done", {63'd0, done_o}, 64'd1);
    check("o_nwr2", 64'(wlog.size()), 64'd1);
    check_wr("o_wr0", 0, 6'd0, 32'hDEAD_BEEF);

    // Reset after six data bytes.
    wlog.delete();
    pulse_start();
    img[0] = 8'h02; img[1] = 8'h00;
    img[2] = 8'h11; img[3] = 8'h22; img[4] = 8'h33; img[5] = 8'h44;
    img[6] = 8'h55; img[7] = 8'h66;
    img_n  = 8;
    send_img(1'b0);
    rst = 1'b1;
    #1;
    check("r_ready", {63'd0, in_ready_o}, 64'd0);
    check("r_we",    {63'd0, mem_we_o},   64'd0);
    check("r_waddr", {58'd0, mem_waddr_o}, 64'd0);
    check("r_wdata", {32'd0, mem_wdata_o}, 64'd0);
    check("r_hold",  {63'd0, core_hold_o}, 64'd1);
    check("r_flags", {61'd0, busy_o, done_o, err_o}, 64'd0);
    check("r_words", {57'd0, words_loaded_o}, 64'd0);
    check("r_nwr",   64'(wlog.size()), 64'd1);
    check_wr("r_wr0", 0, 6'd0, 32'h4433_2211);
    tick();
    rst = 1'b0;
    tick();
    wlog.delete();
    pulse_start();
    set_img2(32'hAABB_CCDD, 32'h0102_0304);
    send_img(1'b0);
    tick();
    check("r_done",  {63'd0, done_o}, 64'd1);
    check("r_words2", {57'd0, words_loaded_o}, 64'd2);
    check_wr("r_wrA", 0, 6'd0, 32'hAABB_CCDD);
    check_wr("r_wrB", 1, 6'd1, 32'h0102_0304);

    // Restart from DONE with a start pulse ignored mid-word.
    wlog.delete();
    pulse_start();
    check("s_hold",  {63'd0, core_hold_o}, 64'd1);
    check("s_done",  {63'd0, done_o},      64'd0);
    check("s_words", {57'd0, words_loaded_o}, 64'd0);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hEF);
    send_byte(8'hBE);
    pulse_start();
    check("s_busy",  {63'd0, busy_o},     64'd1);
    check("s_ready", {63'd0, in_ready_o}, 64'd1);
    send_byte(8'hAD);
    send_byte(8'hDE);
    check("s_we", {63'd0, mem_we_o}, 64'd1);
    tick();
    check("s_done2",  {63'd0, done_o}, 64'd1);
    check("s_words2", {57'd0, words_loaded_o}, 64'd1);
    check("s_nwr",    64'(wlog.size()), 64'd1);
    check_wr("s_wr0", 0, 6'd0, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
